// File: rtl/cnn_pkg.sv
// Shared sizing defaults and state encoding for the row stream scheduler.
// Imported by the scheduler top and its pixel mux.
package cnn_pkg;

  localparam int CNN_ROWS   = 28;
  localparam int CNN_PIXELS = 28;
  localparam int CNN_PIX_W  = 16;
  localparam int CNN_IDX_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    SETUP,
    STREAM,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/row_stream_scheduler_mux.sv
// Selects one pixel out of the flattened row bus.
// Out-of-range indices read as zero.
module row_pixel_mux
  import cnn_pkg::*;
#(
  parameter int PIXELS = CNN_PIXELS,
  parameter int PIX_W  = CNN_PIX_W,
  parameter int IDX_W  = CNN_IDX_W
) (
  input  logic [PIXELS*PIX_W-1:0] row_data,
  input  logic [IDX_W-1:0]        idx,
  output logic [PIX_W-1:0]        pixel
);

  // one-hot compare against every slot keeps the mux index in range
  always_comb begin
    pixel = '0;
    for (int p = 0; p < PIXELS; p++) begin
      if (idx == IDX_W'(p)) pixel = row_data[p*PIX_W +: PIX_W];
    end
  end

endmodule

// File: rtl/row_stream_scheduler.sv
// Walks loaded image rows and streams their pixels as bursts
// over one valid/ready link, with an idle gap between bursts.
module row_stream_scheduler
  import cnn_pkg::*;
#(
  parameter int ROWS       = CNN_ROWS,
  parameter int PIXELS     = CNN_PIXELS,
  parameter int PIX_W      = CNN_PIX_W,
  parameter int IDX_W      = CNN_IDX_W,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pause,
  input  logic [ROWS-1:0]         row_loaded,
  output logic [IDX_W-1:0]        row_sel,
  input  logic [PIXELS*PIX_W-1:0] row_data,
  input  logic [15:0]             row_size,
  input  logic [15:0]             split_size,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIX_W-1:0]        out_data,
  output logic                    out_last,
  output logic                    out_row_end,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = IDX_W + 1;
  localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  state_t state, state_n;
  logic [IDX_W-1:0] sel_n;
  logic [IDX_W-1:0] px, px_n;
  logic [IDX_W-1:0] burst, burst_n;
  logic [CW-1:0] size, size_n;
  logic [CW-1:0] split, split_n;
  logic [CW-1:0] size_c, split_c;
  logic [15:0] gap, gap_n;
  logic busy_n, done_n;
  logic load_beat, adv, gap_done;
  logic last_c, end_c;
  logic [PIX_W-1:0] pix;

  row_pixel_mux #(
    .PIXELS (PIXELS),
    .PIX_W  (PIX_W),
    .IDX_W  (IDX_W)
  ) u_mux (
    .row_data (row_data),
    .idx      (px_n),
    .pixel    (pix)
  );

  // clamp the loader's sizes to what the buffer can hold
  always_comb begin
    size_c = (row_size > 16'(PIXELS)) ? CW'(PIXELS)
                                      : row_size[CW-1:0];
    if (split_size == 16'd0 || split_size > 16'(size_c))
      split_c = size_c;
    else
      split_c = split_size[CW-1:0];
  end

  assign gap_done = ({1'b0, gap} + 17'd1) >= {1'b0, GAP_LIM};
  assign last_c = (CW'(burst_n) == split_n - 1'b1) ||
                  (CW'(px_n) == size_n - 1'b1);
  assign end_c  = (CW'(px_n) == size_n - 1'b1);

  // next state, counters and beat-load decision
  always_comb begin
    state_n   = state;
    sel_n     = row_sel;
    px_n      = px;
    burst_n   = burst;
    size_n    = size;
    split_n   = split;
    gap_n     = gap;
    busy_n    = busy;
    done_n    = done;
    load_beat = 1'b0;
    adv       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WAIT_ROW;
          sel_n   = '0;
          done_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      WAIT_ROW: begin
        if (row_loaded[row_sel] && !pause) state_n = SETUP;
      end
      SETUP: begin
        size_n  = size_c;
        split_n = split_c;
        px_n    = '0;
        burst_n = '0;
        if (size_c == '0) begin
          adv = 1'b1;
        end else begin
          state_n   = STREAM;
          load_beat = 1'b1;
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          if (out_row_end) begin
            adv = 1'b1;
          end else if (out_last) begin
            px_n    = px + 1'b1;
            burst_n = '0;
            if (NO_GAP && !pause) begin
              load_beat = 1'b1;
            end else begin
              state_n = GAP;
              gap_n   = '0;
            end
          end else begin
            px_n      = px + 1'b1;
            burst_n   = burst + 1'b1;
            load_beat = 1'b1;
          end
        end
      end
      GAP: begin
        if (!gap_done) begin
          gap_n = gap + 16'd1;
        end else if (!pause) begin
          state_n   = STREAM;
          load_beat = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      if (row_sel == IDX_W'(ROWS - 1)) begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end else begin
        sel_n   = row_sel + 1'b1;
        state_n = WAIT_ROW;
      end
    end
  end

  // state, counters and registered link outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row_sel     <= '0;
      px          <= '0;
      burst       <= '0;
      size        <= '0;
      split       <= '0;
      gap         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_row_end <= 1'b0;
    end else begin
      state     <= state_n;
      row_sel   <= sel_n;
      px        <= px_n;
      burst     <= burst_n;
      size      <= size_n;
      split     <= split_n;
      gap       <= gap_n;
      busy      <= busy_n;
      done      <= done_n;
      out_valid <= (state_n == STREAM);
      if (load_beat) begin
        out_data    <= pix;
        out_last    <= last_c;
        out_row_end <= end_c;
      end else if (state_n != STREAM) begin
        out_last    <= 1'b0;
        out_row_end <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_stream_scheduler.sv
// Randomized bench for row_stream_scheduler against a
// queue-based model of the expected pixel stream.
module tb_row_stream_scheduler;
  import cnn_pkg::*;

  localparam int R  = 28;
  localparam int P  = 28;
  localparam int W  = 16;
  localparam int IW = 5;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic rst, start, pause, out_ready;
  logic [R-1:0] row_loaded;
  logic [IW-1:0] row_sel;
  logic [P*W-1:0] row_data;
  logic [15:0] row_size, split_size;
  logic out_valid, out_last, out_row_end, busy, done;
  logic [W-1:0] out_data;

  logic [W-1:0] mem [R][P];
  logic [15:0] rs [R];
  logic [15:0] ss [R];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] exp_q [$];
  int exp_total;
  int beats, lasts, ends;
  bit mon_en = 0;
  bit gap_en = 1;
  bit gap_arm = 0;
  int idle = 0;
  bit hold_v = 0;
  logic [31:0] hold_w;
  int rdy_mode = 0;
  int tog = 0;

  always #5 clk = ~clk;

  row_stream_scheduler #(
    .ROWS       (R),
    .PIXELS     (P),
    .PIX_W      (W),
    .IDX_W      (IW),
    .GAP_CYCLES (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .row_loaded  (row_loaded),
    .row_sel     (row_sel),
    .row_data    (row_data),
    .row_size    (row_size),
    .split_size  (split_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_row_end (out_row_end),
    .busy        (busy),
    .done        (done)
  );

  // loader model: combinational read port keyed by row_sel
  always_comb begin
    row_data   = '0;
    row_size   = '0;
    split_size = '0;
    if (row_sel < IW'(R)) begin
      for (int p = 0; p < P; p++)
        row_data[p*W +: W] = mem[row_sel][p];
      row_size   = rs[row_sel];
      split_size = ss[row_sel];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected stream: each row clamped, cut into bursts by modulo
  task automatic build();
    int n, b;
    logic lst, re;
    exp_q.delete();
    for (int r = 0; r < R; r++) begin
      n = (int'(rs[r]) > P) ? P : int'(rs[r]);
      b = (ss[r] == 0 || int'(ss[r]) > n) ? n : int'(ss[r]);
      for (int p = 0; p < n; p++) begin
        lst = ((p % b) == b - 1) || (p == n - 1);
        re  = (p == n - 1);
        exp_q.push_back({9'd0, 5'(r), mem[r][p], lst, re});
      end
    end
    exp_total = exp_q.size();
  endtask

  task automatic cfg_full();
    for (int r = 0; r < R; r++) begin
      rs[r] = 16'd28;
      ss[r] = 16'd7;
      for (int p = 0; p < P; p++) mem[r][p] = W'($urandom);
    end
    row_loaded = '1;
  endtask

  // ready driver
  initial forever begin
    @(posedge clk);
    #1;
    tog++;
    case (rdy_mode)
      1: out_ready = 1'($urandom);
      2: out_ready = tog[0];
      default: out_ready = 1'b1;
    endcase
  end

  // monitor: checks beats, hold stability and gap length
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (hold_v)
        chk("hold", {13'd0, out_valid, out_last, out_row_end, out_data},
            hold_w);
      if (out_valid && gap_arm) begin
        if (gap_en) chk("gap", idle, G);
        gap_arm = 0;
      end
      if (!out_valid && gap_arm) idle++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("extra_beat", 32'(exp_q.size()), 1);
        else
          chk("beat", {9'd0, row_sel, out_data, out_last, out_row_end},
              exp_q.pop_front());
        beats++;
        lasts += int'(out_last);
        ends  += int'(out_row_end);
        if (out_last && !out_row_end) begin
          gap_arm = 1;
          idle = 0;
        end
        hold_v = 0;
      end else begin
        hold_v = out_valid;
        hold_w = {13'd0, out_valid, out_last, out_row_end, out_data};
      end
    end
  end

  task automatic do_reset();
    mon_en = 0;
    rst = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {11'd0, out_valid, out_last, out_row_end, busy,
                      done, row_sel, out_data}, 0);
    rst = 1'b1;
  endtask

  task automatic go(input bit lat);
    build();
    beats = 0;
    lasts = 0;
    ends = 0;
    gap_arm = 0;
    hold_v = 0;
    mon_en = 1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (lat) begin
      chk("busy_set", busy, 1);
      @(posedge clk);
      #1 chk("lat_n1", out_valid, 0);
      @(posedge clk);
      #1 chk("lat_n2", out_valid, 1);
    end
  endtask

  task automatic run_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("done", done, 1);
    chk("busy_clr", busy, 0);
    chk("q_left", exp_q.size(), 0);
    chk("n_beats", beats, exp_total);
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (beats < n && c < 5000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("wait_beats", 32'(beats >= n), 1);
  endtask

  initial begin
    int c;
    int vcnt;
    out_ready = 1'b1;
    row_loaded = '0;
    for (int r = 0; r < R; r++) begin
      rs[r] = '0;
      ss[r] = '0;
      for (int p = 0; p < P; p++) mem[r][p] = '0;
    end
    do_reset();

    // full image, ready always high
    cfg_full();
    rdy_mode = 0;
    go(1);
    run_done(4000);
    chk("full_beats", beats, 784);
    chk("full_lasts", lasts, 112);
    chk("full_ends", ends, 28);

    // clamp, odd split, random sizes, random ready
    for (int r = 0; r < R; r++) begin
      rs[r] = 16'($urandom_range(0, 35));
      ss[r] = 16'($urandom_range(0, 12));
      for (int p = 0; p < P; p++) mem[r][p] = W'($urandom);
    end
    rs[0] = 16'd40; ss[0] = 16'd0;
    rs[1] = 16'd10; ss[1] = 16'd4;
    rdy_mode = 1;
    go(0);
    run_done(8000);

    // 1010 backpressure
    cfg_full();
    rdy_mode = 2;
    go(0);
    run_done(8000);
    chk("bp_lasts", lasts, 112);

    // load gating and an empty row
    cfg_full();
    row_loaded[5] = 1'b0;
    rs[7] = 16'd0;
    rdy_mode = 0;
    go(0);
    c = 0;
    while (row_sel != 5 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("stall_sel", row_sel, 5);
    chk("stall_valid", out_valid, 0);
    chk("stall_busy", busy, 1);
    row_loaded[5] = 1'b1;
    run_done(4000);
    chk("zrow_ends", ends, 27);

    // pause mid-burst, start ignored while busy
    cfg_full();
    gap_en = 0;
    go(0);
    wait_beats(3);
    pause = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      vcnt += int'(out_valid);
    end
    chk("pause_idle", vcnt, 0);
    chk("pause_beats", beats, 7);
    pause = 1'b0;
    @(posedge clk);
    #1 chk("resume", out_valid, 1);
    run_done(4000);
    gap_en = 1;

    // reset in the middle of row 3
    cfg_full();
    go(0);
    wait_beats(3 * 28 + 10);
    mon_en = 0;
    rst = 1'b0;
    #1;
    chk("abort_out", {11'd0, out_valid, out_last, out_row_end, busy,
                      done, row_sel, out_data}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    go(1);
    run_done(4000);
    chk("restart_ends", ends, 28);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
